// File: rtl/riscv_lsu.sv
// Load/store unit: one data-bus transaction per accepted op, load align/extend, RF writeback.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module riscv_lsu #(
    parameter int RD_W    = 5,
    parameter int FUNCT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lsu_req,
    output logic               lsu_ack,
    input  logic [FUNCT_W-1:0] lsu_funct,
    input  logic [31:0]        lsu_addr,
    input  logic [31:0]        lsu_wdata,
    input  logic [RD_W-1:0]    lsu_rd,
    output logic               stall_back,
    output logic [31:0]        data_bif_addr,
    output logic [31:0]        data_bif_wdata,
    output logic [3:0]         data_bif_be,
    output logic               data_bif_we,
    output logic               data_bif_req,
    input  logic               data_bif_ack,
    input  logic [31:0]        data_bif_rdata,
    output logic [31:0]        rf_wdata,
    output logic [RD_W-1:0]    rf_waddr,
    output logic               rf_wr_req,
    input  logic               rf_wr_ack,
    output logic               lsu_exc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_WB
    } state_t;

    state_t             r_state;
    logic [FUNCT_W-1:0] r_funct;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_we;
    logic               r_req;
    logic [RD_W-1:0]    r_rd;
    logic [31:0]        r_rf_wdata;
    logic               r_rf_req;

    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_be;
    logic [31:0]        w_ld_shift;
    logic [31:0]        w_ld_data;

    assign lsu_ack        = (r_state == S_IDLE);
    assign stall_back     = (r_state != S_IDLE);
    assign data_bif_addr  = {r_addr[31:2], 2'b00};
    assign data_bif_wdata = r_wdata;
    assign data_bif_be    = r_be;
    assign data_bif_we    = r_we;
    assign data_bif_req   = r_req;
    assign rf_wdata       = r_rf_wdata;
    assign rf_waddr       = r_rd;
    assign rf_wr_req      = r_rf_req;

    // Store lane replication and byte enables; loads reuse the same enables.
    always_comb begin
        w_st_wdata = lsu_wdata;
        w_st_be    = 4'b1111;
        if (lsu_funct[1]) begin
            w_st_wdata = lsu_wdata;
            w_st_be    = 4'b1111;
        end else if (lsu_funct[0]) begin
            w_st_wdata = {2{lsu_wdata[15:0]}};
            w_st_be    = lsu_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            w_st_wdata = {4{lsu_wdata[7:0]}};
            w_st_be    = 4'b0001 << lsu_addr[1:0];
        end
    end

    always_comb begin
        w_ld_shift = data_bif_rdata;
        w_ld_data  = data_bif_rdata;
        if (r_funct[1]) begin
            w_ld_data = data_bif_rdata;
        end else if (r_funct[0]) begin
            w_ld_shift = data_bif_rdata >> {r_addr[1], 4'b0000};
            w_ld_data  = r_funct[2] ? {16'b0, w_ld_shift[15:0]}
                                    : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
        end else begin
            w_ld_shift = data_bif_rdata >> {r_addr[1:0], 3'b000};
            w_ld_data  = r_funct[2] ? {24'b0, w_ld_shift[7:0]}
                                    : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_exc;
    logic w_misalign;

    assign w_misalign = lsu_funct[1] ? (lsu_addr[1:0] != 2'b00)
                                     : (lsu_funct[0] & lsu_addr[0]);
    assign lsu_exc    = r_exc;
`else
    assign lsu_exc    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_funct    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_req      <= 1'b0;
            r_rd       <= '0;
            r_rf_wdata <= '0;
            r_rf_req   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_exc      <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            r_exc <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (lsu_req) begin
`ifdef MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_exc <= 1'b1;
                        end else
`endif
                        begin
                            r_funct <= lsu_funct;
                            r_addr  <= lsu_addr;
                            r_wdata <= w_st_wdata;
                            r_be    <= w_st_be;
                            r_we    <= lsu_funct[3];
                            r_rd    <= lsu_rd;
                            r_req   <= 1'b1;
                            r_state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (data_bif_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        // Stores and loads to x0 complete without writeback.
                        if (r_funct[3] || (r_rd == '0)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rf_wdata <= w_ld_data;
                            r_rf_req   <= 1'b1;
                            r_state    <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rf_wr_ack) begin
                        r_rf_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a per-cycle compare against a lane/extension model.
// Set MISALIGN_TRAP_EN to exercise the trap build.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req;
    logic        lsu_ack;
    logic [3:0]  lsu_funct;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [4:0]  lsu_rd;
    logic        stall_back;
    logic [31:0] data_bif_addr;
    logic [31:0] data_bif_wdata;
    logic [3:0]  data_bif_be;
    logic        data_bif_we;
    logic        data_bif_req;
    logic        data_bif_ack;
    logic [31:0] data_bif_rdata;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_wr_req;
    logic        rf_wr_ack;
    logic        lsu_exc;

    always #5 clk = ~clk;

    riscv_lsu dut (
        .clk            (clk),
        .reset          (reset),
        .lsu_req        (lsu_req),
        .lsu_ack        (lsu_ack),
        .lsu_funct      (lsu_funct),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_rd         (lsu_rd),
        .stall_back     (stall_back),
        .data_bif_addr  (data_bif_addr),
        .data_bif_wdata (data_bif_wdata),
        .data_bif_be    (data_bif_be),
        .data_bif_we    (data_bif_we),
        .data_bif_req   (data_bif_req),
        .data_bif_ack   (data_bif_ack),
        .data_bif_rdata (data_bif_rdata),
        .rf_wdata       (rf_wdata),
        .rf_waddr       (rf_waddr),
        .rf_wr_req      (rf_wr_req),
        .rf_wr_ack      (rf_wr_ack),
        .lsu_exc        (lsu_exc)
    );

    localparam logic [3:0] F_LB  = 4'b0000;
    localparam logic [3:0] F_LH  = 4'b0001;
    localparam logic [3:0] F_LW  = 4'b0010;
    localparam logic [3:0] F_LBU = 4'b0100;
    localparam logic [3:0] F_LHU = 4'b0101;
    localparam logic [3:0] F_SB  = 4'b1000;
    localparam logic [3:0] F_SH  = 4'b1001;
    localparam logic [3:0] F_SW  = 4'b1010;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  m_funct;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [4:0]  m_rd;
    bit          m_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int mdl_size(input logic [3:0] f);
        if (f[1]) return 4;
        if (f[0]) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] mdl_bwd(input logic [3:0] f, input logic [31:0] wd);
        case (mdl_size(f))
            1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] mdl_be(input logic [3:0] f, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        case (mdl_size(f))
            1:       return 4'(1 << off);
            2:       return 4'(3 << (off & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] mdl_ld(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v;
        int     off;
        off = int'(a[1:0]);
        case (mdl_size(f))
            1: begin
                v = longint'(rd >> (8 * off)) & 255;
                if (!f[2] && v >= 128) v = v - 256;
            end
            2: begin
                off = off & 2;
                v = longint'(rd >> (8 * off)) & 65535;
                if (!f[2] && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("one_outstanding", 32'(data_bif_req & rf_wr_req), 32'd0);
            if (m_on && data_bif_req) begin
                chk("mdl_bus_addr", data_bif_addr, m_addr & 32'hFFFF_FFFC);
                chk("mdl_bus_be", 32'(data_bif_be), 32'(mdl_be(m_funct, m_addr)));
                chk("mdl_bus_we", 32'(data_bif_we), 32'(m_funct[3]));
                if (m_funct[3])
                    chk("mdl_bus_wdata", data_bif_wdata, mdl_bwd(m_funct, m_wdata));
            end
            if (m_on && rf_wr_req) begin
                chk("mdl_rf_wdata", rf_wdata, mdl_ld(m_funct, m_addr, m_rdata));
                chk("mdl_rf_waddr", 32'(rf_waddr), 32'(m_rd));
            end
`ifndef MISALIGN_TRAP_EN
            chk("exc_tied_low", 32'(lsu_exc), 32'd0);
`endif
        end
    end

    task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input int bdly, input logic [31:0] rdat,
                         input int rdly, input logic [31:0] lit_addr,
                         input logic [31:0] lit_wd, input logic [3:0] lit_be,
                         input logic [31:0] lit_rf, input bit hold);
        m_funct = f;
        m_addr  = a;
        m_wdata = wd;
        m_rd    = rd;
        m_rdata = rdat;
        m_on    = 1'b1;
        chk("ack_when_idle", 32'(lsu_ack), 32'd1);
        lsu_req   = 1'b1;
        lsu_funct = f;
        lsu_addr  = a;
        lsu_wdata = wd;
        lsu_rd    = rd;
        @(posedge clk);
        #1;
        if (hold) begin
            lsu_funct = ~f;
            lsu_addr  = a ^ 32'h0000_0F57;
            lsu_wdata = ~wd;
            lsu_rd    = rd + 5'd1;
        end else begin
            lsu_req = 1'b0;
        end
        chk("busy_after_accept", 32'(stall_back), 32'd1);
        chk("no_ack_busy", 32'(lsu_ack), 32'd0);
        chk("bus_req", 32'(data_bif_req), 32'd1);
        chk("lit_bus_addr", data_bif_addr, lit_addr);
        chk("lit_bus_be", 32'(data_bif_be), 32'(lit_be));
        chk("lit_bus_we", 32'(data_bif_we), 32'(f[3]));
        if (f[3]) chk("lit_bus_wdata", data_bif_wdata, lit_wd);
        for (int i = 0; i < bdly; i++) begin
            @(posedge clk);
            #1;
            chk("bus_wait_req", 32'(data_bif_req), 32'd1);
            chk("bus_wait_stall", 32'(stall_back), 32'd1);
        end
        data_bif_ack   = 1'b1;
        data_bif_rdata = rdat;
        @(posedge clk);
        #1;
        data_bif_ack   = 1'b0;
        data_bif_rdata = 32'h0;
        lsu_req        = 1'b0;
        chk("bus_req_drop", 32'(data_bif_req), 32'd0);
        if (f[3] || rd == 5'd0) begin
            chk("idle_after_ack", 32'(lsu_ack), 32'd1);
            chk("no_wb", 32'(rf_wr_req), 32'd0);
        end else begin
            chk("wb_req", 32'(rf_wr_req), 32'd1);
            chk("lit_rf_wdata", rf_wdata, lit_rf);
            chk("lit_rf_waddr", 32'(rf_waddr), 32'(rd));
            for (int i = 0; i < rdly; i++) begin
                @(posedge clk);
                #1;
                chk("wb_hold_req", 32'(rf_wr_req), 32'd1);
                chk("wb_hold_data", rf_wdata, lit_rf);
                chk("wb_hold_stall", 32'(stall_back), 32'd1);
            end
            rf_wr_ack = 1'b1;
            @(posedge clk);
            #1;
            rf_wr_ack = 1'b0;
            chk("wb_done_req", 32'(rf_wr_req), 32'd0);
            chk("wb_done_idle", 32'(lsu_ack), 32'd1);
        end
    endtask

    initial begin
        reset          = 1'b1;
        lsu_req        = 1'b0;
        lsu_funct      = 4'h0;
        lsu_addr       = 32'h0;
        lsu_wdata      = 32'h0;
        lsu_rd         = 5'd0;
        data_bif_ack   = 1'b0;
        data_bif_rdata = 32'h0;
        rf_wr_ack      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(data_bif_req), 32'd0);
        chk("rst_we", 32'(data_bif_we), 32'd0);
        chk("rst_rf_req", 32'(rf_wr_req), 32'd0);
        chk("rst_exc", 32'(lsu_exc), 32'd0);
        chk("rst_addr", data_bif_addr, 32'd0);
        chk("rst_be", 32'(data_bif_be), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_ack", 32'(lsu_ack), 32'd1);
        chk("rst_stall", 32'(stall_back), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op(F_SW, 32'h104, 32'hDEAD_BEEF, 5'd0, 0, 32'h0, 0,
              32'h104, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        do_op(F_SB, 32'h203, 32'h0000_005A, 5'd0, 1, 32'h0, 0,
              32'h200, 32'h5A5A_5A5A, 4'b1000, 32'h0, 1'b1);
        do_op(F_SH, 32'h102, 32'h1234_ABCD, 5'd0, 0, 32'h0, 0,
              32'h100, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0);
        do_op(F_LB, 32'h101, 32'h0, 5'd7, 0, 32'h0000_80FF, 0,
              32'h100, 32'h0, 4'b0010, 32'hFFFF_FF80, 1'b0);
        do_op(F_LBU, 32'h101, 32'h0, 5'd7, 0, 32'h0000_80FF, 0,
              32'h100, 32'h0, 4'b0010, 32'h0000_0080, 1'b0);
        do_op(F_LH, 32'h102, 32'h0, 5'd12, 0, 32'h8001_1234, 3,
              32'h100, 32'h0, 4'b1100, 32'hFFFF_8001, 1'b1);
        do_op(F_LHU, 32'h100, 32'h0, 5'd4, 2, 32'h1234_F00D, 1,
              32'h100, 32'h0, 4'b0011, 32'h0000_F00D, 1'b0);
        do_op(F_LB, 32'h303, 32'h0, 5'd2, 0, 32'h7F00_0000, 0,
              32'h300, 32'h0, 4'b1000, 32'h0000_007F, 1'b0);
        do_op(F_LW, 32'h108, 32'h0, 5'd31, 1, 32'hCAFE_BABE, 0,
              32'h108, 32'h0, 4'b1111, 32'hCAFE_BABE, 1'b0);
        do_op(F_LW, 32'h100, 32'h0, 5'd0, 4, 32'h1357_9BDF, 0,
              32'h100, 32'h0, 4'b1111, 32'h0, 1'b0);

        // Reset while the bus is outstanding, then a stale ack.
        m_funct   = F_LW;
        m_addr    = 32'h10C;
        m_rd      = 5'd9;
        m_rdata   = 32'h0BAD_F00D;
        lsu_req   = 1'b1;
        lsu_funct = F_LW;
        lsu_addr  = 32'h10C;
        lsu_rd    = 5'd9;
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
        chk("mid_rst_req_before", 32'(data_bif_req), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_req", 32'(data_bif_req), 32'd0);
        chk("mid_rst_ack", 32'(lsu_ack), 32'd1);
        reset          = 1'b0;
        data_bif_ack   = 1'b1;
        data_bif_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        data_bif_ack = 1'b0;
        chk("late_ack_req", 32'(data_bif_req), 32'd0);
        chk("late_ack_wb", 32'(rf_wr_req), 32'd0);
        chk("late_ack_idle", 32'(lsu_ack), 32'd1);
        @(posedge clk);
        #1;
        chk("late_ack_wb2", 32'(rf_wr_req), 32'd0);

`ifdef MISALIGN_TRAP_EN
        m_on      = 1'b0;
        lsu_req   = 1'b1;
        lsu_funct = F_LW;
        lsu_addr  = 32'h102;
        lsu_rd    = 5'd3;
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
        chk("trap_exc", 32'(lsu_exc), 32'd1);
        chk("trap_no_req", 32'(data_bif_req), 32'd0);
        chk("trap_idle", 32'(lsu_ack), 32'd1);
        @(posedge clk);
        #1;
        chk("trap_exc_pulse", 32'(lsu_exc), 32'd0);
        chk("trap_no_req2", 32'(data_bif_req), 32'd0);
        chk("trap_no_wb", 32'(rf_wr_req), 32'd0);
`else
        do_op(F_LW, 32'h102, 32'h0, 5'd3, 0, 32'h1122_3344, 0,
              32'h100, 32'h0, 4'b1111, 32'h1122_3344, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
